// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit codes (also used by the ALU decoder) and
// the width of a collector entry tag.
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'd0,
    UNIT_LOGIC = 2'd1,
    UNIT_CMP   = 2'd2,
    UNIT_SHIFT = 2'd3
  } unit_e;

  localparam int unsigned UNIT_W      = 2;
  localparam int unsigned ENTRY_TAG_W = UNIT_W + 1;

  // Entry = {unit, carry, data}
  function automatic int unsigned entry_width(input int unsigned data_w);
    return data_w + ENTRY_TAG_W;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with a registered head word, occupancy counter and
// synchronous active-high reset. Head reads zero whenever the FIFO is empty.
module alu_sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4,
  localparam int unsigned aw = $clog2(depth),
  localparam int unsigned cw = aw + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             valid,
  output logic [cw-1:0]    count,
  output logic             full_c,
  output logic             empty_c
);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [aw-1:0]    rd_next;
  logic [cw-1:0]    cnt_next;
  logic [width-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == cw'(depth));
  assign empty_c = (count == '0);

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  always_comb begin
    do_pop    = pop && !empty_c;
    do_push   = push && (!full_c || do_pop);
    rd_next   = rd_ptr + aw'(do_pop);
    cnt_next  = count + cw'(do_push) - cw'(do_pop);
    head_next = '0;
    if (cnt_next == '0) begin
      head_next = '0;
    end else if (do_push && (count == cw'(do_pop))) begin
      head_next = wdata;
    end else begin
      head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      rd_ptr <= rd_next;
      count  <= cnt_next;
      head   <= head_next;
      valid  <= (cnt_next != '0);
    end
  end

  // Storage is not reset; only slots behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects per-unit ALU results, normalises them to one tagged word and
// queues them for writeback. Define ALU_COLLECT_PARITY_EN to add out_parity.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int unsigned width       = 16,
  parameter int unsigned arith_width = 2 * width,
  parameter int unsigned shift_width = width + 1,
  parameter int unsigned cmp_width   = 3,
  parameter int unsigned depth       = 4,
  localparam int unsigned cw = $clog2(depth) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arith_flag,
  input  logic                   logic_flag,
  input  logic                   cmp_flag,
  input  logic                   shift_flag,
  input  logic                   carry_out,
  input  logic [arith_width-1:0] arith_out,
  input  logic [width-1:0]       logic_out,
  input  logic [cmp_width-1:0]   cmp_out,
  input  logic [shift_width-1:0] shift_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [arith_width-1:0] out_data,
  output logic [1:0]             out_unit,
  output logic                   out_carry,
`ifdef ALU_COLLECT_PARITY_EN
  output logic                   out_parity,
`endif
  output logic [cw-1:0]          count,
  output logic                   overflow,
  output logic                   multi_hit
);

  localparam int unsigned base_w = entry_width(arith_width);
`ifdef ALU_COLLECT_PARITY_EN
  localparam int unsigned fifo_w = base_w + 1;
`else
  localparam int unsigned fifo_w = base_w;
`endif

  logic [3:0]             hits;
  logic                   push;
  logic                   pop;
  logic                   multi_c;
  unit_e                  sel_unit;
  logic                   sel_carry;
  logic [arith_width-1:0] sel_data;
  logic [base_w-1:0]      entry;
  logic [fifo_w-1:0]      wdata;
  logic [fifo_w-1:0]      head;
  logic                   full_c;
  logic                   empty_c;

  assign hits    = {arith_flag, logic_flag, cmp_flag, shift_flag};
  assign push    = |hits;
  assign multi_c = |(hits & (hits - 4'd1));
  assign pop     = out_valid && out_ready;

  // Priority select arith > logic > cmp > shift, zero-extending narrow results.
  always_comb begin
    sel_unit  = UNIT_ARITH;
    sel_carry = 1'b0;
    sel_data  = '0;
    if (arith_flag) begin
      sel_unit  = UNIT_ARITH;
      sel_carry = carry_out;
      sel_data  = arith_out;
    end else if (logic_flag) begin
      sel_unit = UNIT_LOGIC;
      sel_data = arith_width'(logic_out);
    end else if (cmp_flag) begin
      sel_unit = UNIT_CMP;
      sel_data = arith_width'(cmp_out);
    end else if (shift_flag) begin
      sel_unit = UNIT_SHIFT;
      sel_data = arith_width'(shift_out);
    end
  end

  assign entry = {sel_unit, sel_carry, sel_data};

`ifdef ALU_COLLECT_PARITY_EN
  assign wdata      = {^entry, entry};
  assign out_parity = head[base_w];
`else
  assign wdata = entry;
`endif

  alu_sync_fifo #(
    .width (fifo_w),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .head    (head),
    .valid   (out_valid),
    .count   (count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  assign out_data  = head[arith_width-1:0];
  assign out_carry = head[arith_width];
  assign out_unit  = head[arith_width+2:arith_width+1];

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      multi_hit <= 1'b0;
    end else begin
      if (push && full_c && !pop) begin
        overflow <= 1'b1;
      end
      if (multi_c) begin
        multi_hit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector (default depth 4).
module tb_alu_result_collector;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 2 * W;
  localparam int unsigned SW = W + 1;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          arith_flag, logic_flag, cmp_flag, shift_flag;
  logic          carry_out;
  logic [AW-1:0] arith_out;
  logic [W-1:0]  logic_out;
  logic [CW-1:0] cmp_out;
  logic [SW-1:0] shift_out;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [1:0]    out_unit;
  logic          out_carry;
`ifdef ALU_COLLECT_PARITY_EN
  logic          out_parity;
`endif
  logic [2:0]    count;
  logic          overflow;
  logic          multi_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_collector dut (
    .clk        (clk),
    .rst        (rst),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag),
    .carry_out  (carry_out),
    .arith_out  (arith_out),
    .logic_out  (logic_out),
    .cmp_out    (cmp_out),
    .shift_out  (shift_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_unit   (out_unit),
    .out_carry  (out_carry),
`ifdef ALU_COLLECT_PARITY_EN
    .out_parity (out_parity),
`endif
    .count      (count),
    .overflow   (overflow),
    .multi_hit  (multi_hit)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    arith_flag = 1'b0;
    logic_flag = 1'b0;
    cmp_flag   = 1'b0;
    shift_flag = 1'b0;
    carry_out  = 1'b0;
  endtask

  task automatic push_arith(input logic [AW-1:0] d);
    arith_flag = 1'b1;
    arith_out  = d;
    tick();
    clear_flags();
  endtask

  initial begin
    logic [AW-1:0] exp_q[$];

    rst       = 1'b1;
    out_ready = 1'b0;
    arith_out = '0;
    logic_out = '0;
    cmp_out   = '0;
    shift_out = '0;
    clear_flags();
    tick();
    tick();
    rst = 1'b0;

    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_data", 64'(out_data), 64'd0);
    check("reset_unit", 64'(out_unit), 64'd0);
    check("reset_carry", 64'(out_carry), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_multi", 64'(multi_hit), 64'd0);

    // Arith entry with carry, visible after the pushing edge.
    arith_flag = 1'b1;
    arith_out  = 32'hFFFF_FFFE;
    carry_out  = 1'b1;
    tick();
    clear_flags();
    check("arith_valid", 64'(out_valid), 64'd1);
    check("arith_data", 64'(out_data), 64'hFFFF_FFFE);
    check("arith_unit", 64'(out_unit), 64'd0);
    check("arith_carry", 64'(out_carry), 64'd1);
    check("arith_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("arith_pop_count", 64'(count), 64'd0);
    check("arith_pop_valid", 64'(out_valid), 64'd0);

    // Shift entry pushed with out_ready already high: no bypass, carry ignored.
    shift_flag = 1'b1;
    shift_out  = 17'h1_8000;
    carry_out  = 1'b1;
    out_ready  = 1'b1;
    tick();
    clear_flags();
    check("shift_count", 64'(count), 64'd1);
    check("shift_data", 64'(out_data), 64'h0001_8000);
    check("shift_unit", 64'(out_unit), 64'd3);
    check("shift_carry", 64'(out_carry), 64'd0);
    tick();
    out_ready = 1'b0;
    check("shift_pop_count", 64'(count), 64'd0);
    check("shift_pop_valid", 64'(out_valid), 64'd0);

    // Logic + cmp together: logic wins, multi_hit sticks.
    logic_flag = 1'b1;
    cmp_flag   = 1'b1;
    logic_out  = 16'h00AA;
    cmp_out    = 3'b100;
    tick();
    clear_flags();
    check("multi_count", 64'(count), 64'd1);
    check("multi_data", 64'(out_data), 64'h0000_00AA);
    check("multi_unit", 64'(out_unit), 64'd1);
    check("multi_flag", 64'(multi_hit), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("multi_sticky", 64'(multi_hit), 64'd1);
    check("multi_pop_count", 64'(count), 64'd0);

    // Fill to depth, then push+pop when full: no overflow.
    for (int i = 0; i < 4; i++) begin
      push_arith(AW'(32'h10 + i));
      exp_q.push_back(AW'(32'h10 + i));
    end
    check("full_count", 64'(count), 64'd4);
    check("full_overflow", 64'(overflow), 64'd0);
    check("full_head", 64'(out_data), 64'h10);
    out_ready = 1'b1;
    push_arith(32'h14);
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'h14);
    check("fullpp_count", 64'(count), 64'd4);
    check("fullpp_overflow", 64'(overflow), 64'd0);
    check("fullpp_head", 64'(out_data), 64'h11);

    // Push into full with no pop: dropped, overflow set.
    push_arith(32'h15);
    check("drop_count", 64'(count), 64'd4);
    check("drop_overflow", 64'(overflow), 64'd1);

    // Drain in order; dropped entry must not appear.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_count", 64'(count), 64'(4 - k));
      check("drain_data", 64'(out_data), 64'(exp_q[k]));
      tick();
    end
    out_ready = 1'b0;
    check("drained_valid", 64'(out_valid), 64'd0);
    check("drained_count", 64'(count), 64'd0);
    check("drained_data", 64'(out_data), 64'd0);
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Queue 3 entries (one with a double hit), then reset mid-stream.
    arith_flag = 1'b1;
    shift_flag = 1'b1;
    arith_out  = 32'h0000_1234;
    carry_out  = 1'b1;
    tick();
    clear_flags();
    push_arith(32'h22);
    push_arith(32'h33);
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_head", 64'(out_data), 64'h1234);
    check("pre_rst_carry", 64'(out_carry), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_multi", 64'(multi_hit), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_unit", 64'(out_unit), 64'd0);
    check("rst_carry", 64'(out_carry), 64'd0);
`ifdef ALU_COLLECT_PARITY_EN
    check("rst_parity", 64'(out_parity), 64'd0);
`endif

    // Cmp entry after reset: discarded entries must not resurface.
    cmp_flag = 1'b1;
    cmp_out  = 3'b101;
    tick();
    clear_flags();
    check("cmp_count", 64'(count), 64'd1);
    check("cmp_data", 64'(out_data), 64'h5);
    check("cmp_unit", 64'(out_unit), 64'd2);
`ifdef ALU_COLLECT_PARITY_EN
    // {2'b10, 1'b0, 32'h5}: three ones -> parity 1
    check("cmp_parity", 64'(out_parity), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the signed ALU top.
- Each cycle it takes the four unit results (arith/logic/cmp/shift) and their per-unit valid flags, and selects the active result.
- Normalises the result to one 2*width-bit word tagged with the unit code and carry, then queues it in a small FIFO.
- Drains to the register-file/writeback side through a valid/ready handshake, so back-pressure never stalls the ALU.

Parameters:
- width, 16, ALU operand width; must match the ALU instance.
- arith_width, 2*width, arith result width and output data width.
- shift_width, width+1, shift result width.
- cmp_width, 3, compare result width.
- depth, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- arith_flag  in  1  arith result valid this cycle.
- logic_flag  in  1  logic result valid.
- cmp_flag  in  1  compare result valid.
- shift_flag  in  1  shift result valid.
- carry_out  in  1  arith carry, sampled only with arith_flag.
- arith_out  in  arith_width  arith result.
- logic_out  in  width  logic result.
- cmp_out  in  cmp_width  compare result.
- shift_out  in  shift_width  shift result.
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  arith_width  normalised result.
- out_unit  out  2  source unit: 0 arith, 1 logic, 2 cmp, 3 shift (same encoding as alu_func[3:2]).
- out_carry  out  1  carry; 0 for non-arith entries.
- count  out  clog2(depth)+1  current occupancy.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- multi_hit  out  1  sticky: more than one flag was high in the same cycle.

Behaviour:
- Reset (rst high at a clock edge) clears pointers, count, overflow and multi_hit. out_valid=0; out_data, out_unit and out_carry read 0. Reset mid-stream discards all queued entries.
- push = OR of the four flags. Selection priority is arith > logic > cmp > shift.
- If two or more flags are high in one cycle, only the highest-priority unit is pushed and multi_hit is set.
- Normalisation:
  - arith_out passes through unchanged.
  - logic_out, cmp_out and shift_out are zero-extended to arith_width. shift_out bit width is a data bit, not a sign.
- Entry format is {unit, carry, data}. carry = carry_out only for arith entries, else 0.
- Latency: a flag at edge N is written at edge N. If the FIFO was empty, out_valid=1 and the entry is on the outputs after edge N (registered FIFO, no combinational flag-to-output path).
- Handshake:
  - The head pops on an edge where out_valid && out_ready.
  - out_data, out_unit and out_carry are held stable while out_valid && !out_ready.
- Full (count==depth), push, no pop: the entry is dropped, overflow is set, and count is unchanged.
- Full, push and pop in the same cycle: both occur and count stays at depth; no overflow.
- Empty, push with out_ready high: the entry is written and not popped the same cycle (no bypass).
- Pointers wrap modulo depth. count goes 0..depth inclusive.
- overflow and multi_hit clear only on rst.

Optional Feature:
- Macro ALU_COLLECT_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR) over {unit, carry, data}.
  - Parity is computed at push and stored in the FIFO as one extra bit.
  - out_parity reads 0 at reset.
- Undefined: the port and storage bit are absent; everything else is identical.

Decomposition:
- Shared package alu_pkg:
  - unit code constants UNIT_ARITH=0, UNIT_LOGIC=1, UNIT_CMP=2, UNIT_SHIFT=3.
  - Entry-width helper constant.
  - The same codes serve the ALU decoder.
- One sub-module alu_sync_fifo: parameterised width/depth, synchronous reset, push/pop/full/empty/count, registered head output.
- The collector top holds the priority select, normalisation, sticky flags and (optionally) parity.

Test Plan:
- Reset, then arith_flag with arith_out=32'hFFFF_FFFE, carry_out=1 -> next cycle out_valid=1, out_data=32'hFFFF_FFFE, out_unit=0, out_carry=1, count=1.
- shift_flag with shift_out=17'h1_8000, then out_ready=1 -> out_data=32'h0001_8000, out_unit=3, out_carry=0, pops after 1 cycle, count back to 0.
- logic_flag and cmp_flag high together with logic_out=16'h00AA, cmp_out=3'b100 -> single logic entry 32'h0000_00AA is pushed, multi_hit=1.
- out_ready=0, push 5 entries with depth=4 -> count=4, overflow=1, entries 1-4 drain in order once out_ready=1.
- Full FIFO with push and out_ready=1 together -> count stays 4, overflow stays 0, new entry appears last.
- rst pulsed with 3 entries queued -> next cycle out_valid=0, count=0, overflow=0, multi_hit=0, outputs read 0.
